parity_step_counter: RTL
========================

Name: parity_step_counter

Overview:
Parametrised even/odd sequence counter. It emits out = 2*k + odd, where k is an internal modulo-LIMIT index and odd selects the sequence parity. Compared with the fixed 3-bit generator it replaces, it adds:
- generic width and modulus
- up/down direction, enable and synchronous load with clamping
- a registered wrap pulse and a registered compare-hit flag

It feeds address/sequence generators that need interleaved even/odd streams.

Parameters:
- WIDTH, 4, output width in bits; index k is WIDTH-1 bits wide; legal range 2..32.
- LIMIT, 8, index modulus; k runs 0..LIMIT-1; legal range 2..2**(WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  advance index by one step when high.
- dir  input  1  1 = count up, 0 = count down.
- odd  input  1  parity select: 1 = odd sequence, 0 = even; sampled on every load/advance edge.
- load  input  1  synchronous load of index from load_val.
- load_val  input  WIDTH-1  index to load; clamped to LIMIT-1 when >= LIMIT.
- cmp_val  input  WIDTH  compare value for hit.
- out  output  WIDTH  registered sequence value {k, parity}.
- wrap  output  1  one-cycle registered pulse when the index wraps.
- hit  output  1  registered: high in the cycle after out == cmp_val is first presented.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state changes on the rising edge of clk.
- Reset: k=0, out=0 (parity bit 0 regardless of odd), wrap=0, hit=0. rst has priority over all other inputs and may be asserted mid-count.
- Priority each edge: rst > load > en > hold.
- Load:
  - k <= min(load_val, LIMIT-1); out[0] <= odd; wrap <= 0.
  - dir and en are ignored that cycle.
- Advance (en=1, load=0):
  - Up: k <= (k==LIMIT-1) ? 0 : k+1; wrap <= (k==LIMIT-1).
  - Down: k <= (k==0) ? LIMIT-1 : k-1; wrap <= (k==0).
  - out[0] <= odd.
- Hold (en=0, load=0): k and out unchanged; wrap <= 0.
- out[WIDTH-1:1] always equals k. out[0] is the registered parity.
- Changing odd with en=0 does not alter out until the next load/advance edge.
- Latency: out reflects the new value one cycle after the load/advance edge; wrap is asserted in the same cycle as the wrapped out value.
- hit:
  - hit <= (out == cmp_val) each edge, i.e. one cycle behind out.
  - hit is 0 in the cycle after reset.
- Arithmetic: all index math is unsigned, WIDTH-1 bits, with explicit modulo-LIMIT compare. There is no reliance on natural overflow, so non-power-of-2 LIMIT works.
- Elaboration check: fail if LIMIT > 2**(WIDTH-1) or WIDTH < 2.

Decomposition:
- Shared package: DIR_UP=1'b1, DIR_DOWN=1'b0, PAR_EVEN=1'b0, PAR_ODD=1'b1.
- One sub-module, mod_index_counter (params CW, LIMIT). It owns k, load clamping, up/down modulo step and the wrap pulse.
- Top-level owns the parity register, output concatenation and the hit compare.

Test Plan:
- Reset/even up-count (WIDTH=4, LIMIT=8): rst 1 cycle, en=1, dir=1, odd=0 -> out 0,2,4,...,14,0; wrap high only with out=0 after 14.
- Odd non-power-of-2 (LIMIT=6): odd=1, up -> out 1,3,5,7,9,11,1; wrap with the second 1. Then dir=0 from k=0 -> out 11 with wrap=1.
- Load clamp/priority (LIMIT=6): load=1, en=1, load_val=7, odd=0 -> out=10 (k=5), wrap=0; next advance up -> out=0, wrap=1.
- Hold and parity change: en=0 at out=6, toggle odd -> out stays 6 for 3 cycles; en=1 -> out=9.
- Mid-operation reset: rst during wrap cycle with en=1 -> next out=0, wrap=0, hit=0; counting resumes 0,2,... (odd=0).
- Compare: cmp_val=5, odd=1, up from 0 -> hit=1 exactly one cycle after out=5, deasserted next cycle.

Source files
------------

// File: rtl/parity_step_counter_pkg.sv
// Shared constants for the even/odd sequence counter.
// Direction and parity encodings used by top, index counter and users.
package parity_step_counter_pkg;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/parity_step_counter_mod_index_counter.sv
// Modulo-LIMIT up/down index counter with clamped load.
// Produces a registered pulse when the index wraps either way.
module mod_index_counter
  import parity_step_counter_pkg::*;
#(
  parameter int CW    = 3,
  parameter int LIMIT = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_dir,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic [CW-1:0] o_k,
  output logic          o_wrap
);
  localparam logic [CW-1:0] KMAX = CW'(LIMIT - 1);

  logic [CW-1:0] r_k;
  logic          r_wrap;
  logic [CW-1:0] w_clamp;
  logic          w_at_max;
  logic          w_at_min;

  assign w_clamp  = (i_load_val > KMAX) ? KMAX : i_load_val;
  assign w_at_max = (r_k == KMAX);
  assign w_at_min = (r_k == '0);

  // Explicit compares keep non-power-of-2 moduli correct.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k    <= '0;
      r_wrap <= 1'b0;
    end else if (i_load) begin
      r_k    <= w_clamp;
      r_wrap <= 1'b0;
    end else if (i_en) begin
      if (i_dir == DIR_UP) begin
        r_k    <= w_at_max ? '0 : r_k + CW'(1);
        r_wrap <= w_at_max;
      end else begin
        r_k    <= w_at_min ? KMAX : r_k - CW'(1);
        r_wrap <= w_at_min;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign o_k    = r_k;
  assign o_wrap = r_wrap;
endmodule

// File: rtl/parity_step_counter.sv
// Even/odd sequence counter: out = {k, parity}.
// Registered wrap pulse and one-cycle-late compare hit.
module parity_step_counter
  import parity_step_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             odd,
  input  logic             load,
  input  logic [WIDTH-2:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             hit
);
  if (WIDTH < 2 || LIMIT < 2 ||
      64'(LIMIT) > (64'd1 << (WIDTH - 1))) begin : g_bad_params
    $error("parity_step_counter: illegal WIDTH/LIMIT");
  end

  logic [WIDTH-2:0] w_k;
  logic             w_wrap;
  logic             r_par;
  logic             r_hit;

  mod_index_counter #(
    .CW    (WIDTH - 1),
    .LIMIT (LIMIT)
  ) u_idx (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_dir      (dir),
    .i_load     (load),
    .i_load_val (load_val),
    .o_k        (w_k),
    .o_wrap     (w_wrap)
  );

  // Parity only moves on edges that also move the index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= PAR_EVEN;
      r_hit <= 1'b0;
    end else begin
      if (load || en) r_par <= odd;
      r_hit <= (out == cmp_val);
    end
  end

  assign out  = {w_k, r_par};
  assign wrap = w_wrap;
  assign hit  = r_hit;
endmodule
